cam_lookup_ctrl: RTL and testbench

Request-side controller for the `tcam` block: the initiator that drives the CAM's write and search ports on behalf of a client.
- Accepts LOOKUP / INSERT / DELETE requests over a valid/ready handshake and sequences the CAM search-then-capture timing.
- Tracks slot occupancy with a valid bitmap and allocates free slots.
- Returns one response per request over a second valid/ready handshake.
- Sits between client logic and one `tcam` instance that shares clk/rstN.

---
 rtl/cam_pkg.sv | 21 ++
 rtl/free_slot_enc.sv | 28 ++
 rtl/cam_lookup_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_cam_lookup_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared definitions for the CAM request controller: op codes, FSM states
// and the reserved key value that the CAM uses to mark empty slots.
package cam_pkg;

    localparam logic [1:0] OP_LOOKUP = 2'b00;
    localparam logic [1:0] OP_INSERT = 2'b01;
    localparam logic [1:0] OP_DELETE = 2'b10;
    localparam logic [1:0] OP_RSVD   = 2'b11;

    // Empty CAM slots hold this value, so it can never be a client key.
    localparam int unsigned RESERVED_KEY = 32'd0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SRCH  = 3'd1,
        ST_CAPT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

endpackage

// File: rtl/free_slot_enc.sv
// Lowest-index priority encoder over a free-slot mask; any_free flags
// that at least one slot is available.
module free_slot_enc #(
    parameter int N  = 16,
    parameter int AW = $clog2(N)
) (
    input  logic [N-1:0]  free_mask,
    output logic [AW-1:0] free_idx,
    output logic          any_free
);

    logic [AW-1:0] idx_s;
    logic          any_s;

    // Scan upward and keep the first set bit seen
    always_comb begin
        idx_s = '0;
        any_s = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx_s = (free_mask[i] && !any_s) ? AW'(i) : idx_s;
            any_s = any_s | free_mask[i];
        end
    end

    assign free_idx = idx_s;
    assign any_free = any_s;

endmodule

// File: rtl/cam_lookup_ctrl.sv
// Request-side controller for a tcam: sequences search/capture and write
// cycles for LOOKUP/INSERT/DELETE, tracks slot occupancy, and returns one
// response per request.
module cam_lookup_ctrl
    import cam_pkg::*;
#(
    parameter int MEM_SIZE   = 16,
    parameter int MEM_LENGTH = 16,
    localparam int AW = $clog2(MEM_SIZE)
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [MEM_LENGTH-1:0] req_key,
    input  logic [AW-1:0]         req_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_hit,
    output logic [AW-1:0]         rsp_addr,
    output logic                  rsp_err,
    output logic [AW:0]           occupancy,
    output logic                  cam_we,
    output logic [AW-1:0]         cam_waddr,
    output logic [MEM_LENGTH-1:0] cam_data,
    output logic                  cam_search,
    input  logic [AW-1:0]         cam_saddr,
    input  logic [MEM_LENGTH-1:0] cam_sdata,
    input  logic                  cam_found
);

    localparam int OCC_W = AW + 1;

    state_t                state_r;
    logic [1:0]            op_r;
    logic [MEM_LENGTH-1:0] key_r;
    logic [AW-1:0]         addr_r;
    logic [MEM_SIZE-1:0]   valid_r;
    logic [OCC_W-1:0]      occ_r;
    logic                  req_ready_r;
    logic                  rsp_valid_r;
    logic                  rsp_hit_r;
    logic [AW-1:0]         rsp_addr_r;
    logic                  rsp_err_r;
    logic                  cam_we_r;
    logic [AW-1:0]         cam_waddr_r;
    logic [MEM_LENGTH-1:0] cam_data_r;
    logic                  cam_search_r;

    logic [MEM_SIZE-1:0]   free_mask_s;
    logic [AW-1:0]         free_idx_s;
    logic                  any_free_s;
    logic                  hit_s;
    logic                  key_rsvd_s;
    logic                  req_err_s;

    assign free_mask_s = ~valid_r;

    free_slot_enc #(
        .N  (MEM_SIZE),
        .AW (AW)
    ) u_free_slot_enc (
        .free_mask (free_mask_s),
        .free_idx  (free_idx_s),
        .any_free  (any_free_s)
    );

    // A match only counts if the slot is live and the CAM returned our key
    assign hit_s = cam_found & valid_r[cam_saddr] & (cam_sdata == key_r);

    assign key_rsvd_s = (req_key == MEM_LENGTH'(RESERVED_KEY));

    // Errors that can be decided the moment a request is accepted
    always_comb begin
        req_err_s = 1'b0;
        case (req_op)
            OP_LOOKUP: req_err_s = key_rsvd_s;
            OP_INSERT: req_err_s = key_rsvd_s;
            OP_DELETE: req_err_s = ~valid_r[req_addr];
            default:   req_err_s = 1'b1;
        endcase
    end

    // Request sequencing FSM; also owns the bitmap, occupancy and all outputs
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_r      <= ST_IDLE;
            op_r         <= OP_LOOKUP;
            key_r        <= '0;
            addr_r       <= '0;
            valid_r      <= '0;
            occ_r        <= '0;
            req_ready_r  <= 1'b0;
            rsp_valid_r  <= 1'b0;
            rsp_hit_r    <= 1'b0;
            rsp_addr_r   <= '0;
            rsp_err_r    <= 1'b0;
            cam_we_r     <= 1'b0;
            cam_waddr_r  <= '0;
            cam_data_r   <= '0;
            cam_search_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    req_ready_r <= 1'b1;
                    if (req_valid && req_ready_r) begin
                        op_r        <= req_op;
                        key_r       <= req_key;
                        addr_r      <= req_addr;
                        req_ready_r <= 1'b0;
                        if (req_err_s) begin
                            state_r     <= ST_RESP;
                            rsp_valid_r <= 1'b1;
                            rsp_hit_r   <= 1'b0;
                            rsp_addr_r  <= '0;
                            rsp_err_r   <= 1'b1;
                        end else if (req_op == OP_DELETE) begin
                            state_r     <= ST_WRITE;
                            cam_we_r    <= 1'b1;
                            cam_waddr_r <= req_addr;
                            cam_data_r  <= '0;
                        end else begin
                            state_r      <= ST_SRCH;
                            cam_search_r <= 1'b1;
                            cam_data_r   <= req_key;
                        end
                    end
                end
                ST_SRCH: begin
                    state_r <= ST_CAPT;
                end
                ST_CAPT: begin
                    cam_search_r <= 1'b0;
                    if (op_r == OP_INSERT && !hit_s && any_free_s) begin
                        // cam_data_r still holds the key to be written
                        state_r     <= ST_WRITE;
                        cam_we_r    <= 1'b1;
                        cam_waddr_r <= free_idx_s;
                    end else begin
                        state_r     <= ST_RESP;
                        rsp_valid_r <= 1'b1;
                        cam_data_r  <= '0;
                        if (op_r == OP_LOOKUP) begin
                            rsp_hit_r  <= hit_s;
                            rsp_addr_r <= hit_s ? cam_saddr : '0;
                            rsp_err_r  <= 1'b0;
                        end else if (op_r == OP_INSERT && hit_s) begin
                            rsp_hit_r  <= 1'b1;
                            rsp_addr_r <= cam_saddr;
                            rsp_err_r  <= 1'b0;
                        end else begin
                            rsp_hit_r  <= 1'b0;
                            rsp_addr_r <= '0;
                            rsp_err_r  <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    cam_we_r    <= 1'b0;
                    cam_data_r  <= '0;
                    state_r     <= ST_RESP;
                    rsp_valid_r <= 1'b1;
                    rsp_hit_r   <= 1'b0;
                    rsp_err_r   <= 1'b0;
                    if (op_r == OP_INSERT) begin
                        valid_r[cam_waddr_r] <= 1'b1;
                        rsp_addr_r           <= cam_waddr_r;
                        if (occ_r < OCC_W'(MEM_SIZE)) begin
                            occ_r <= occ_r + OCC_W'(1);
                        end
                    end else begin
                        valid_r[addr_r] <= 1'b0;
                        rsp_addr_r      <= addr_r;
                        if (occ_r != OCC_W'(0)) begin
                            occ_r <= occ_r - OCC_W'(1);
                        end
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_r     <= ST_IDLE;
                        req_ready_r <= 1'b1;
                        rsp_valid_r <= 1'b0;
                        rsp_hit_r   <= 1'b0;
                        rsp_addr_r  <= '0;
                        rsp_err_r   <= 1'b0;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    req_ready_r  <= 1'b0;
                    rsp_valid_r  <= 1'b0;
                    cam_we_r     <= 1'b0;
                    cam_search_r <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_r;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_hit    = rsp_hit_r;
    assign rsp_addr   = rsp_addr_r;
    assign rsp_err    = rsp_err_r;
    assign occupancy  = occ_r;
    assign cam_we     = cam_we_r;
    assign cam_waddr  = cam_waddr_r;
    assign cam_data   = cam_data_r;
    assign cam_search = cam_search_r;

endmodule

// File: tb/tb_cam_lookup_ctrl.sv
// Scoreboard bench for cam_lookup_ctrl with a behavioural tcam attached.
module tb_cam_lookup_ctrl;

    localparam int MS = 16;
    localparam int ML = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rstN = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_op = 2'b00;
    logic [ML-1:0] req_key = '0;
    logic [AW-1:0] req_addr = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic          rsp_hit;
    logic [AW-1:0] rsp_addr;
    logic          rsp_err;
    logic [AW:0]   occupancy;
    logic          cam_we;
    logic [AW-1:0] cam_waddr;
    logic [ML-1:0] cam_data;
    logic          cam_search;
    logic [AW-1:0] cam_saddr;
    logic [ML-1:0] cam_sdata;
    logic          cam_found;

    cam_lookup_ctrl #(.MEM_SIZE(MS), .MEM_LENGTH(ML)) dut (
        .clk(clk), .rstN(rstN),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_key(req_key), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit),
        .rsp_addr(rsp_addr), .rsp_err(rsp_err), .occupancy(occupancy),
        .cam_we(cam_we), .cam_waddr(cam_waddr), .cam_data(cam_data),
        .cam_search(cam_search), .cam_saddr(cam_saddr), .cam_sdata(cam_sdata),
        .cam_found(cam_found)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // Behavioural tcam: lowest matching index registered after a search cycle
    logic [ML-1:0] cam_mem [MS];
    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < MS; i++) cam_mem[i] <= '0;
            cam_found <= 1'b0;
            cam_saddr <= '0;
            cam_sdata <= '0;
        end else begin
            if (cam_we) cam_mem[cam_waddr] <= cam_data;
            if (cam_search) begin
                cam_found <= 1'b0;
                for (int i = MS - 1; i >= 0; i--) begin
                    if (cam_mem[i] == cam_data) begin
                        cam_found <= 1'b1;
                        cam_saddr <= AW'(i);
                        cam_sdata <= cam_mem[i];
                    end
                end
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: table of stored keys by slot
    typedef struct {
        logic          hit;
        logic [AW-1:0] addr;
        logic          err;
        int            lat;
        int            occ;
        int            wr;
        logic [AW-1:0] waddr;
        logic [ML-1:0] wdata;
    } exp_t;

    logic [ML-1:0] m_key [MS];
    bit            m_used [MS];
    int            m_occ;
    exp_t          exp_q [$];
    int            acc_cyc;

    task automatic model_reset();
        for (int i = 0; i < MS; i++) begin
            m_used[i] = 1'b0;
            m_key[i]  = '0;
        end
        m_occ = 0;
        exp_q.delete();
    endtask

    function automatic exp_t model(input logic [1:0] op, input logic [ML-1:0] key, input logic [AW-1:0] addr);
        exp_t e;
        int found;
        int fr;
        e.hit = 1'b0; e.addr = '0; e.err = 1'b0; e.lat = 1; e.wr = 0;
        e.waddr = '0; e.wdata = '0;
        if (op == 2'b11 || (op != 2'b10 && key == 16'h0000)) begin
            e.err = 1'b1;
        end else if (op == 2'b10) begin
            if (m_used[addr]) begin
                e.addr = addr; e.lat = 2; e.wr = 1; e.waddr = addr; e.wdata = '0;
                m_used[addr] = 1'b0;
                m_occ--;
            end else begin
                e.err = 1'b1;
            end
        end else begin
            found = -1;
            for (int i = MS - 1; i >= 0; i--)
                if (m_used[i] && m_key[i] == key) found = i;
            e.lat = 3;
            if (found >= 0) begin
                e.hit = 1'b1;
                e.addr = AW'(found);
            end else if (op == 2'b01) begin
                fr = -1;
                for (int i = MS - 1; i >= 0; i--)
                    if (!m_used[i]) fr = i;
                if (fr < 0) begin
                    e.err = 1'b1;
                end else begin
                    e.addr = AW'(fr); e.lat = 4; e.wr = 1;
                    e.waddr = AW'(fr); e.wdata = key;
                    m_used[fr] = 1'b1;
                    m_key[fr] = key;
                    m_occ++;
                end
            end
        end
        e.occ = m_occ;
        return e;
    endfunction

    // Monitor: compares each response on its first cycle, then checks stability
    bit            in_rsp = 1'b0;
    int            wr_cnt = 0;
    logic [AW-1:0] last_waddr;
    logic [ML-1:0] last_wdata;
    logic [AW+1:0] held;
    exp_t          cur;
    always @(posedge clk) begin
        #1;
        if (!rstN) begin
            in_rsp = 1'b0;
            wr_cnt = 0;
        end else begin
            if (cam_we && cam_search) chk("we_and_search", 32'd1, 32'd0);
            if (cam_we) begin
                wr_cnt++;
                last_waddr = cam_waddr;
                last_wdata = cam_data;
            end
            if (!rsp_valid) begin
                in_rsp = 1'b0;
            end else if (!in_rsp) begin
                in_rsp = 1'b1;
                held = {rsp_hit, rsp_addr, rsp_err};
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    cur = exp_q.pop_front();
                    chk("rsp_hit", 32'(rsp_hit), 32'(cur.hit));
                    chk("rsp_addr", 32'(rsp_addr), 32'(cur.addr));
                    chk("rsp_err", 32'(rsp_err), 32'(cur.err));
                    chk("latency", 32'(cyc - acc_cyc), 32'(cur.lat));
                    chk("occupancy", 32'(occupancy), 32'(cur.occ));
                    chk("write_count", 32'(wr_cnt), 32'(cur.wr));
                    if (cur.wr == 1 && wr_cnt == 1) begin
                        chk("cam_waddr", 32'(last_waddr), 32'(cur.waddr));
                        chk("cam_wdata", 32'(last_wdata), 32'(cur.wdata));
                    end
                end
                wr_cnt = 0;
            end else begin
                chk("rsp_stable", 32'({rsp_hit, rsp_addr, rsp_err}), 32'(held));
                chk("req_ready_in_rsp", 32'(req_ready), 32'd0);
            end
        end
    end

    task automatic do_req(input logic [1:0] op, input logic [ML-1:0] key, input logic [AW-1:0] addr, input int dly);
        int t;
        exp_q.push_back(model(op, key, addr));
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_key = key; req_addr = addr;
        t = 0;
        while (!req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 32'd1, 32'd0);
            req_valid = 1'b0;
            exp_q.delete();
            return;
        end
        acc_cyc = cyc;
        @(negedge clk);
        req_valid = 1'b0;
        t = 0;
        while (!rsp_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!rsp_valid) begin
            chk("rsp_timeout", 32'd1, 32'd0);
            exp_q.delete();
            return;
        end
        repeat (dly) @(negedge clk);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rstN = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    initial begin
        int t;
        logic [1:0]    op;
        logic [ML-1:0] key;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_outputs", 32'({rsp_valid, rsp_hit, rsp_err, cam_we, cam_search}), 32'd0);
        chk("rst_cam_data", 32'(cam_data), 32'd0);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        rstN = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("idle_req_ready", 32'(req_ready), 32'd1);

        // Directed sequence
        do_req(2'b00, 16'h1234, 4'd0, 0);
        do_req(2'b01, 16'h1234, 4'd0, 0);
        do_req(2'b01, 16'hBEEF, 4'd0, 1);
        do_req(2'b00, 16'hBEEF, 4'd0, 0);
        do_req(2'b01, 16'h1234, 4'd0, 0);
        do_req(2'b10, 16'h0000, 4'd0, 0);
        do_req(2'b00, 16'h1234, 4'd0, 0);
        do_req(2'b10, 16'h0000, 4'd0, 0);
        do_req(2'b01, 16'h1234, 4'd0, 5);
        do_req(2'b00, 16'hBEEF, 4'd0, 5);

        // Fill every slot, then overflow and reserved-key/op errors
        apply_reset();
        for (int k = 1; k <= MS; k++) do_req(2'b01, ML'(k), 4'd0, 0);
        do_req(2'b01, 16'd17, 4'd0, 0);
        do_req(2'b01, 16'h0000, 4'd0, 0);
        do_req(2'b00, 16'h0000, 4'd0, 0);
        do_req(2'b11, 16'h0005, 4'd3, 0);
        do_req(2'b00, 16'd16, 4'd0, 0);
        do_req(2'b10, 16'h0000, 4'd15, 0);
        do_req(2'b01, 16'd20, 4'd0, 0);

        // Randomized traffic over a small key pool
        for (int n = 0; n < 250; n++) begin
            t = int'($urandom_range(0, 9));
            op = (t < 4) ? 2'b00 : (t < 7) ? 2'b01 : (t < 9) ? 2'b10 : 2'b11;
            key = ($urandom_range(0, 19) == 0) ? 16'h0000 : ML'($urandom_range(1, 24));
            do_req(op, key, AW'($urandom_range(0, MS - 1)), int'($urandom_range(0, 3)));
        end

        // Reset while a write is on the CAM port
        apply_reset();
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'b01; req_key = 16'h0055;
        t = 0;
        while (!req_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        t = 0;
        while (!cam_we && t < 10) begin
            @(negedge clk);
            t++;
        end
        chk("we_before_reset", 32'(cam_we), 32'd1);
        #2;
        rstN = 1'b0;
        #1;
        chk("abort_flags", 32'({req_ready, rsp_valid, rsp_hit, rsp_err, cam_we, cam_search}), 32'd0);
        chk("abort_addr", 32'({rsp_addr, cam_waddr}), 32'd0);
        chk("abort_cam_data", 32'(cam_data), 32'd0);
        chk("abort_occupancy", 32'(occupancy), 32'd0);
        @(negedge clk);
        rstN = 1'b1;
        model_reset();
        @(negedge clk);
        do_req(2'b00, 16'h0055, 4'd0, 0);
        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
